// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control sequencer for the MIPS datapath.
//
// Accepts one instruction per instr_valid/instr_ready handshake and walks it
// through DECODE, EXEC, MEM and WB. All outputs are Moore-decoded from the
// state and the captured instruction. The one exception is branch_taken,
// which follows alu_zero during EXEC.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   instr_valid, instr  instruction offer (opcode [31:26], funct [5:0])
//   instr_ready         high only in IDLE
//   alu_zero            ALU zero flag, used by beq in EXEC
//   mem_ack             memory completion, used only in MEM
//   alu_func            ALU function code (bit 3 = invert B, carry-in 1)
//   alu_src_a           0 = PC, 1 = regA
//   alu_src_b           00 regB, 01 const 4, 10 sext imm16, 11 zext imm16
//   pc_write            load PC with the ALU result (PC+4)
//   branch_taken        load PC with the branch target
//   mem_read, mem_write memory strobes, held until mem_ack
//   reg_write           register-file write enable
//   reg_dst             1 = rd, 0 = rt
//   mem_to_reg          1 = memory data, 0 = ALU result
//   illegal             one-cycle pulse for an unsupported instruction
module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic [3:0]  alu_func,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        branch_taken,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal
);

  localparam logic [3:0] FuncAnd = 4'b0000;
  localparam logic [3:0] FuncOr  = 4'b0001;
  localparam logic [3:0] FuncXor = 4'b0010;
  localparam logic [3:0] FuncAdd = 4'b0100;
  localparam logic [3:0] FuncSub = 4'b1100;
  localparam logic [3:0] FuncSlt = 4'b1101;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBSext = 2'b10;
  localparam logic [1:0] SrcBZext = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;

  // Decode of the captured instruction
  logic [5:0] opcode, funct;
  logic       legal, is_rtype, is_lw, is_sw, is_beq;
  logic [3:0] exec_func;
  logic [1:0] exec_src_b;

  // Only opcode and funct matter to this block.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_q[25:6];

  always_comb begin
    opcode     = instr_q[31:26];
    funct      = instr_q[5:0];
    legal      = 1'b0;
    is_rtype   = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    exec_func  = FuncAnd;
    exec_src_b = SrcBReg;
    case (opcode)
      6'h00: begin
        is_rtype = 1'b1;
        legal    = 1'b1;
        case (funct)
          6'h20:   exec_func = FuncAdd;
          6'h22:   exec_func = FuncSub;
          6'h24:   exec_func = FuncAnd;
          6'h25:   exec_func = FuncOr;
          6'h26:   exec_func = FuncXor;
          6'h2A:   exec_func = FuncSlt;
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin legal = 1'b1; exec_func = FuncAdd; exec_src_b = SrcBSext; end
      6'h0A: begin legal = 1'b1; exec_func = FuncSlt; exec_src_b = SrcBSext; end
      6'h0C: begin legal = 1'b1; exec_func = FuncAnd; exec_src_b = SrcBZext; end
      6'h0D: begin legal = 1'b1; exec_func = FuncOr;  exec_src_b = SrcBZext; end
      6'h0E: begin legal = 1'b1; exec_func = FuncXor; exec_src_b = SrcBZext; end
      6'h23: begin legal = 1'b1; is_lw = 1'b1; exec_func = FuncAdd; exec_src_b = SrcBSext; end
      6'h2B: begin legal = 1'b1; is_sw = 1'b1; exec_func = FuncAdd; exec_src_b = SrcBSext; end
      6'h04: begin legal = 1'b1; is_beq = 1'b1; exec_func = FuncSub; exec_src_b = SrcBReg; end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    instr_ready  = 1'b0;
    alu_func     = FuncAnd;
    alu_src_a    = 1'b0;
    alu_src_b    = SrcBReg;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (legal) begin
          alu_src_b = SrcBFour;
          alu_func  = FuncAdd;
          pc_write  = 1'b1;
          state_d   = StExec;
        end else begin
          illegal = 1'b1;
          state_d = StIdle;
        end
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_func  = exec_func;
        alu_src_b = exec_src_b;
        if (is_beq) begin
          branch_taken = alu_zero;
          state_d      = StIdle;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        // Address computation stays on the ALU while memory is busy.
        alu_src_a = 1'b1;
        alu_func  = exec_func;
        alu_src_b = exec_src_b;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ack) begin
          state_d = is_lw ? StWb : StIdle;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_lw;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed test-plan sequences
// with literal expectations, then randomized traffic, with a cycle-level
// reference model compared on every falling edge.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        instr_ready;
  logic [3:0]  alu_func;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write, branch_taken, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .alu_zero     (alu_zero),
    .mem_ack      (mem_ack),
    .alu_func     (alu_func),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_write     (pc_write),
    .branch_taken (branch_taken),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .illegal      (illegal)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction classes: 0 R-type, 1 I-type ALU, 2 lw, 3 sw, 4 beq.
  function automatic void classify(input logic [31:0] w, output bit ok, output int cls,
                                   output logic [3:0] f, output logic [1:0] b);
    ok = 1'b1; cls = 1; f = 4'b0100; b = 2'b10;
    case (w[31:26])
      6'h00: begin
        cls = 0; b = 2'b00;
        case (w[5:0])
          6'h20: f = 4'b0100;
          6'h22: f = 4'b1100;
          6'h24: f = 4'b0000;
          6'h25: f = 4'b0001;
          6'h26: f = 4'b0010;
          6'h2A: f = 4'b1101;
          default: ok = 1'b0;
        endcase
      end
      6'h08: begin f = 4'b0100; b = 2'b10; end
      6'h0A: begin f = 4'b1101; b = 2'b10; end
      6'h0C: begin f = 4'b0000; b = 2'b11; end
      6'h0D: begin f = 4'b0001; b = 2'b11; end
      6'h0E: begin f = 4'b0010; b = 2'b11; end
      6'h23: cls = 2;
      6'h2B: cls = 3;
      6'h04: begin cls = 4; f = 4'b1100; b = 2'b00; end
      default: ok = 1'b0;
    endcase
  endfunction

  // age: cycles since accept (0 = idle); acked: lw has finished its memory wait.
  int          age = 0;
  bit          acked = 1'b0;
  logic [31:0] m_ins = 32'h0;

  function automatic void model_step(input logic [31:0] cur, input int a, input bit k,
                                     input logic v, input logic [31:0] w, input logic ack,
                                     output logic [31:0] nins, output int na, output bit nk);
    bit ok; int cls; logic [3:0] f; logic [1:0] b;
    classify(cur, ok, cls, f, b);
    nins = cur; na = a; nk = k;
    if (a == 0) begin
      if (v) begin nins = w; na = 1; nk = 1'b0; end
    end else if (a == 1) begin
      na = ok ? 2 : 0;
    end else if (a == 2) begin
      na = (cls == 4) ? 0 : 3;
    end else if ((cls == 2 || cls == 3) && !k) begin
      if (ack && cls == 3) na = 0;
      else begin
        na = a + 1;
        if (ack) nk = 1'b1;
      end
    end else begin
      na = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] t_ins; int t_age; bit t_k;
    if (!rst_n) begin
      age   <= 0;
      acked <= 1'b0;
      m_ins <= 32'h0;
    end else begin
      model_step(m_ins, age, acked, instr_valid, instr, mem_ack, t_ins, t_age, t_k);
      m_ins <= t_ins;
      age   <= t_age;
      acked <= t_k;
    end
  end

  // Vector: [15] ready [14:11] func [10] src_a [9:8] src_b [7] pc_write
  // [6] branch [5] mem_read [4] mem_write [3] reg_write [2] reg_dst [1] mem_to_reg [0] illegal
  always @(negedge clk) begin
    bit ok; int cls; logic [3:0] f; logic [1:0] b;
    logic [15:0] exp, mask, got;
    if (rst_n) begin
      classify(m_ins, ok, cls, f, b);
      exp  = 16'h0;
      mask = 16'hFFF9;
      got  = {instr_ready, alu_func, alu_src_a, alu_src_b, pc_write, branch_taken,
              mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal};
      if (age == 0) begin
        exp[15] = 1'b1;
      end else if (age == 1) begin
        if (ok) begin
          exp[14:11] = 4'b0100; exp[9:8] = 2'b01; exp[7] = 1'b1;
        end else begin
          exp[0] = 1'b1; mask[14:8] = 7'h0;
        end
      end else if (age == 2) begin
        exp[14:11] = f; exp[10] = 1'b1; exp[9:8] = b;
        exp[6] = (cls == 4) && alu_zero;
      end else if ((cls == 2 || cls == 3) && !acked) begin
        exp[14:11] = f; exp[10] = 1'b1; exp[9:8] = b;
        exp[5] = (cls == 2); exp[4] = (cls == 3);
      end else begin
        mask[14:8] = 7'h0; mask[2:1] = 2'b11;
        exp[3] = 1'b1; exp[2] = (cls == 0); exp[1] = (cls == 2);
      end
      chk("model_outputs", {16'h0, got & mask}, {16'h0, exp & mask});
    end
  end

  // ---------------- directed helpers ----------------
  logic [3:0] r_dfunc, r_efunc;
  logic [1:0] r_dsrcb, r_esrcb;
  logic       r_esrca, r_rd, r_m2r;
  int         r_cyc, n_pcw, n_bt, n_mr, n_mw, n_rw, n_ill;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from IDLE and observe it until instr_ready returns.
  task automatic run_instr(input logic [31:0] ins, input int ack_after, input logic zero);
    int n_mem = 0;
    r_cyc = 0; n_pcw = 0; n_bt = 0; n_mr = 0; n_mw = 0; n_rw = 0; n_ill = 0;
    r_rd = 1'b0; r_m2r = 1'b0;
    r_dfunc = 4'hx; r_efunc = 4'hx; r_dsrcb = 2'bx; r_esrcb = 2'bx; r_esrca = 1'bx;
    instr = ins; alu_zero = zero; mem_ack = 1'b0; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (instr_ready) begin r_cyc = c; break; end
      if (c == 1) begin r_dfunc = alu_func; r_dsrcb = alu_src_b; end
      if (c == 2) begin r_efunc = alu_func; r_esrca = alu_src_a; r_esrcb = alu_src_b; end
      n_pcw += int'(pc_write);
      n_bt  += int'(branch_taken);
      n_mr  += int'(mem_read);
      n_mw  += int'(mem_write);
      n_rw  += int'(reg_write);
      n_ill += int'(illegal);
      if (reg_write) begin r_rd = reg_dst; r_m2r = mem_to_reg; end
      if (mem_read || mem_write) begin
        n_mem++;
        mem_ack = (n_mem >= ack_after);
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    chk("ready_returns_within_bound", 32'(r_cyc != 0), 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [11] = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                            6'h23, 6'h2B, 6'h04, 6'h3F};
    logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h03, 6'h21};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom % 11];
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom % 8];
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int pulses_pc, pulses_rw;
    #3;
    chk("reset_alu_func", 32'(alu_func), 32'h0);
    chk("reset_strobes", {21'h0, pc_write, branch_taken, mem_read, mem_write, reg_write,
                          illegal, alu_src_a, alu_src_b, 2'b00}, 32'h0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(instr_ready), 32'd1);

    // add $t0,$t1,$t2
    run_instr(32'h012A4020, 1, 1'b0);
    chk("add_decode_func", 32'(r_dfunc), 32'h4);
    chk("add_decode_srcb", 32'(r_dsrcb), 32'h1);
    chk("add_exec_func", 32'(r_efunc), 32'h4);
    chk("add_exec_srca", 32'(r_esrca), 32'h1);
    chk("add_exec_srcb", 32'(r_esrcb), 32'h0);
    chk("add_pc_write_count", 32'(n_pcw), 32'd1);
    chk("add_reg_write_count", 32'(n_rw), 32'd1);
    chk("add_reg_dst", 32'(r_rd), 32'd1);
    chk("add_ready_latency", 32'(r_cyc), 32'd4);

    run_instr(32'h01095022, 1, 1'b0);
    chk("sub_exec_func", 32'(r_efunc), 32'hC);
    run_instr(32'h0109502A, 1, 1'b0);
    chk("slt_exec_func", 32'(r_efunc), 32'hD);
    run_instr(32'h3508FFFF, 1, 1'b0);
    chk("ori_exec_func", 32'(r_efunc), 32'h1);
    chk("ori_exec_srcb", 32'(r_esrcb), 32'h3);
    chk("ori_reg_dst", 32'(r_rd), 32'd0);

    run_instr(32'h1109000C, 1, 1'b1);
    chk("beq_taken_count", 32'(n_bt), 32'd1);
    chk("beq_no_reg_write", 32'(n_rw), 32'd0);
    chk("beq_ready_latency", 32'(r_cyc), 32'd3);
    run_instr(32'h1109000C, 1, 1'b0);
    chk("beq_not_taken", 32'(n_bt), 32'd0);

    run_instr(32'h8D090004, 3, 1'b0);
    chk("lw_mem_read_cycles", 32'(n_mr), 32'd3);
    chk("lw_mem_to_reg", 32'(r_m2r), 32'd1);
    chk("lw_reg_write_count", 32'(n_rw), 32'd1);
    chk("lw_ready_latency", 32'(r_cyc), 32'd7);
    run_instr(32'hAD090004, 1, 1'b0);
    chk("sw_mem_write_cycles", 32'(n_mw), 32'd1);
    chk("sw_no_reg_write", 32'(n_rw), 32'd0);
    chk("sw_ready_latency", 32'(r_cyc), 32'd4);

    run_instr(32'hFC000000, 1, 1'b0);
    chk("illegal_op_pulse", 32'(n_ill), 32'd1);
    chk("illegal_op_no_pc_write", 32'(n_pcw), 32'd0);
    chk("illegal_op_latency", 32'(r_cyc), 32'd2);
    run_instr(32'h00000003, 1, 1'b0);
    chk("illegal_funct_pulse", 32'(n_ill), 32'd1);
    chk("illegal_funct_latency", 32'(r_cyc), 32'd2);

    // Reset while lw waits in MEM
    instr = 32'h8D090004; instr_valid = 1'b1; mem_ack = 1'b0;
    tick();
    instr_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_read) break;
    end
    chk("lw_reached_mem", 32'(mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("mem_read_async_drop", 32'(mem_read), 32'd0);
    #1 rst_n = 1'b1;
    run_instr(32'h012A4020, 1, 1'b0);
    chk("post_reset_add_latency", 32'(r_cyc), 32'd4);
    chk("post_reset_add_reg_write", 32'(n_rw), 32'd1);

    // instr_valid held high: one capture per IDLE visit
    pulses_pc = 0; pulses_rw = 0;
    instr = 32'h012A4020; instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses_pc += int'(pc_write);
      pulses_rw += int'(reg_write);
    end
    instr_valid = 1'b0;
    chk("held_valid_pc_pulses", 32'(pulses_pc), 32'd3);
    chk("held_valid_rw_pulses", 32'(pulses_rw), 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_ready) break;
    end

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom % 151 == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      instr_valid = ($urandom % 3) != 0;
      instr       = rand_instr();
      alu_zero    = 1'($urandom % 2);
      mem_ack     = ($urandom % 3) == 0;
    end
    instr_valid = 1'b0;
    mem_ack     = 1'b1;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
